div_issue_ctrl: RTL

Issue/response controller for the 32-bit pipelined unsigned non-restoring divider in the M-extension execute stage. It turns RV32M DIV/DIVU/REM/REMU requests into unsigned magnitude operands and feeds the divider one per cycle. A sideband pipeline carries tag, sign and special-case state alongside each operation; the block applies the RISC-V sign and divide-by-zero rules to the result and buffers responses behind a valid/ready handshake with credit-based flow control.

---
 rtl/div_pkg.sv | 27 ++
 rtl/div_resp_fifo.sv | 60 ++++++
 rtl/div_issue_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared encodings and sideband record for the RV32M divide issue controller.
package div_pkg;

  // funct3[1:0] encodings of the M-extension divide group
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  // Default latency of the external pipelined divider
  localparam int DIV_LATENCY_DEF = 33;

  // Width of the tag carried in the sideband record
  localparam int SB_TAG_W = 5;

  // State travelling alongside each operation through the divider latency
  typedef struct packed {
    logic                valid;
    logic [SB_TAG_W-1:0] tag;
    logic                is_rem;
    logic                neg;
    logic                dz;
  } div_sb_t;

endpackage

// File: rtl/div_resp_fifo.sv
// Flop-based synchronous response FIFO with synchronous clear.
// Storage is not reset; the output is forced to zero while empty.
module div_resp_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             pop_eff;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign pop_eff   = pop && out_valid;

  // Storage write; upstream credits guarantee a free slot on every push
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= ptr_inc(wr_ptr);
      if (pop_eff) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/response controller for the pipelined unsigned divider: converts
// RV32M requests to magnitudes, tracks sign/zero state in a sideband pipe
// matched to the divider latency, fixes up results and buffers responses.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_W       = 5,
  parameter int DIV_LATENCY = DIV_LATENCY_DEF,
  parameter int RESP_DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0]      req_tag,
  output logic [DATA_WIDTH-1:0] div_dividend,
  output logic [DATA_WIDTH-1:0] div_divisor,
  input  logic [DATA_WIDTH-1:0] div_quotient,
  input  logic [DATA_WIDTH-1:0] div_remainder,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [TAG_W-1:0]      resp_tag,
  output logic                  busy
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  // Two's-complement magnitude for signed ops; most negative value maps to 2^(W-1)
  function automatic logic [DATA_WIDTH-1:0] to_mag(input logic [DATA_WIDTH-1:0] x,
                                                   input logic is_signed);
    logic signed [DATA_WIDTH-1:0] xs;
    xs = x;
    if (is_signed && (xs < 0)) return $unsigned(-xs);
    return x;
  endfunction

  // Restore the sign of a divider result
  function automatic logic [DATA_WIDTH-1:0] apply_sign(input logic [DATA_WIDTH-1:0] v,
                                                       input logic neg);
    logic signed [DATA_WIDTH-1:0] vs;
    vs = v;
    return neg ? $unsigned(-vs) : v;
  endfunction

  logic                  accept;
  logic                  is_signed;
  logic                  pop;
  logic [CNT_W-1:0]      cnt;
  div_sb_t               sb_in;
  div_sb_t               sb_p [DIV_LATENCY];
  div_sb_t               sb_last;
  logic [DATA_WIDTH-1:0] result;
  logic                  fifo_push;
  logic [DATA_WIDTH+TAG_W-1:0] fifo_out;

  assign req_ready = !flush && (cnt < CNT_W'(RESP_DEPTH));
  assign accept    = req_valid && req_ready;
  assign busy      = (cnt != '0);
  assign pop       = resp_valid && resp_ready;

  // Operand conditioning: DIV and REM have funct3[0] clear
  assign is_signed    = !req_op[0];
  assign div_dividend = to_mag(req_a, is_signed);
  assign div_divisor  = to_mag(req_b, is_signed);

  // Sideband record for the incoming request
  always_comb begin
    sb_in        = '0;
    sb_in.valid  = accept;
    sb_in.tag    = req_tag;
    sb_in.is_rem = req_op[1];
    sb_in.dz     = (req_b == '0);
    case (div_op_e'(req_op))
      OP_DIV:  sb_in.neg = (req_a[DATA_WIDTH-1] ^ req_b[DATA_WIDTH-1]) && (req_b != '0);
      OP_REM:  sb_in.neg = req_a[DATA_WIDTH-1];
      default: sb_in.neg = 1'b0;
    endcase
  end

  // Sideband pipe advancing every cycle; only the valid bits are reset or flushed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DIV_LATENCY; i++) sb_p[i].valid <= 1'b0;
    end else begin
      sb_p[0] <= sb_in;
      for (int i = 1; i < DIV_LATENCY; i++) sb_p[i] <= sb_p[i-1];
      if (flush) begin
        for (int i = 0; i < DIV_LATENCY; i++) sb_p[i].valid <= 1'b0;
      end
    end
  end

  // Final stage: aligned with the divider output
  assign sb_last = sb_p[DIV_LATENCY-1];

  // Sign and divide-by-zero fixup
  always_comb begin
    result = '0;
    if (sb_last.is_rem)  result = apply_sign(div_remainder, sb_last.neg);
    else if (sb_last.dz) result = '1;
    else                 result = apply_sign(div_quotient, sb_last.neg);
  end

  assign fifo_push = sb_last.valid && !flush;

  // Credit counter: in-flight plus queued operations
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  div_resp_fifo #(
    .WIDTH(DATA_WIDTH + TAG_W),
    .DEPTH(RESP_DEPTH)
  ) u_resp_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .push     (fifo_push),
    .push_data({result, sb_last.tag}),
    .pop      (pop),
    .out_valid(resp_valid),
    .out_data (fifo_out)
  );

  assign resp_data = fifo_out[DATA_WIDTH+TAG_W-1:TAG_W];
  assign resp_tag  = fifo_out[TAG_W-1:0];

endmodule
